// File: rtl/stopwatch_ctrl.sv
// Stopwatch control block: conditions three raw keys (synchronise, debounce,
// press detect), runs the IDLE/RUN/PAUSE/LAP mode machine and the
// tenth-second prescaler. Every output comes straight from a flop.
module stopwatch_ctrl #(
  parameter int unsigned CLK_PER_TICK = 5000000,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_clear_n,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       lap_clr,
  output logic       lap_frozen,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  localparam int K_START = 0;
  localparam int K_LAP   = 1;
  localparam int K_CLEAR = 2;

  localparam int DB_W = 20;
  localparam int PS_W = 26;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_TICK - 1);

  // ---------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------
  logic [2:0]            key_raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            level_q, level_d;
  logic [2:0]            arm_q, arm_d;
  logic [2:0]            press_q, press_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            fill_q;

  assign key_raw = {key_clear_n, key_lap_n, key_start_n};

  // Debounce each synced key; a key is armed only once it has been seen
  // released with real samples, so a key held through reset stays silent.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    level_d  = level_q;
    arm_d    = arm_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (fill_q == 2'd2 && sync2_q[k] && level_q[k]) begin
        arm_d[k] = 1'b1;
      end
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          level_d[k] = sync2_q[k];
          press_d[k] = arm_q[k] & ~sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Synchroniser, debounce and press-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of code order.
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      level_q  <= '1;
      arm_q    <= '0;
      press_q  <= '0;
      db_cnt_q <= '0;
      fill_q   <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      arm_q    <= arm_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end

  // One event per cycle: start beats lap beats clear.
  logic ev_start, ev_lap, ev_clear;
  assign ev_start = press_q[K_START];
  assign ev_lap   = press_q[K_LAP] & ~press_q[K_START];
  assign ev_clear = press_q[K_CLEAR] & ~press_q[K_START] & ~press_q[K_LAP];

  // ---------------------------------------------------------------------
  // Mode machine and prescaler
  // ---------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            lap_load_q, lap_load_d;
  logic            lap_clr_q, lap_clr_d;
  logic            lap_frozen_q, running_q;
  logic            counting;

  // Next mode, pulse requests and prescaler value for the coming cycle.
  always_comb begin
    state_d    = state_q;
    cnt_clr_d  = 1'b0;
    lap_load_d = 1'b0;
    lap_clr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_start) state_d = RUN;
        else if (ev_clear) begin
          cnt_clr_d = 1'b1;
          lap_clr_d = 1'b1;
        end
      end
      RUN: begin
        if (ev_start) state_d = PAUSE;
        else if (ev_lap) begin
          lap_load_d = 1'b1;
          state_d    = LAP;
        end
      end
      LAP: begin
        if (ev_start) state_d = PAUSE;
        else if (ev_lap) lap_load_d = 1'b1;
        else if (ev_clear) state_d = RUN;
      end
      PAUSE: begin
        if (ev_start) state_d = RUN;
        else if (ev_lap) lap_clr_d = 1'b1;
        else if (ev_clear) begin
          cnt_clr_d = 1'b1;
          lap_clr_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The prescaler advances only out of a counting cycle, so the held
    // value in PAUSE resumes exactly where it stopped.
    counting = (state_q == RUN) || (state_q == LAP);
    if (state_d == IDLE)        presc_d = '0;
    else if (counting)          presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    else                        presc_d = presc_q;
    tick_d = ((state_d == RUN) || (state_d == LAP)) && (presc_d == PS_LAST);
  end

  // Registered mode, prescaler and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      cnt_clr_q    <= 1'b0;
      lap_load_q   <= 1'b0;
      lap_clr_q    <= 1'b0;
      lap_frozen_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      cnt_clr_q    <= cnt_clr_d;
      lap_load_q   <= lap_load_d;
      lap_clr_q    <= lap_clr_d;
      lap_frozen_q <= (state_d == LAP);
      running_q    <= (state_d == RUN) || (state_d == LAP);
    end
  end

  assign state      = state_q;
  assign tick_en    = tick_q;
  assign cnt_clr    = cnt_clr_q;
  assign lap_load   = lap_load_q;
  assign lap_clr    = lap_clr_q;
  assign lap_frozen = lap_frozen_q;
  assign running    = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_PER_TICK=10, DEBOUNCE_CYC=4.
// A key driven low at a falling edge is acted on 7 rising edges later
// (2 sync + 4 debounce + 1 event-to-state).
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start_n, key_lap_n, key_clear_n;
  logic       tick_en, cnt_clr, lap_load, lap_clr, lap_frozen, running;
  logic [1:0] state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned c_tick, c_cnt_clr, c_lap_load, c_lap_clr;

  stopwatch_ctrl #(
    .CLK_PER_TICK(10),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start_n(key_start_n),
    .key_lap_n  (key_lap_n),
    .key_clear_n(key_clear_n),
    .tick_en    (tick_en),
    .cnt_clr    (cnt_clr),
    .lap_load   (lap_load),
    .lap_clr    (lap_clr),
    .lap_frozen (lap_frozen),
    .running    (running),
    .state      (state)
  );

  always #5 clk = ~clk;

  // {tick_en, cnt_clr, lap_load, lap_clr, lap_frozen, running, state}
  function automatic logic [7:0] outs();
    return {tick_en, cnt_clr, lap_load, lap_clr, lap_frozen, running, state};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clr_cnt();
    c_tick = 0; c_cnt_clr = 0; c_lap_load = 0; c_lap_clr = 0;
  endtask

  // Advance to the next falling edge and tally the pulse outputs there.
  task automatic cyc();
    @(negedge clk);
    c_tick     += {31'd0, tick_en};
    c_cnt_clr  += {31'd0, cnt_clr};
    c_lap_load += {31'd0, lap_load};
    c_lap_clr  += {31'd0, lap_clr};
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (state !== exp && n < 40);
    check({tag, "_state"}, 32'(state), 32'(exp));
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (tick_en !== 1'b1 && n < 20);
    check(tag, 32'(tick_en), 32'd1);
  endtask

  // Counts counting cycles, starting with the current one as 1, up to the tick.
  task automatic run_to_tick(output int r);
    r = 1;
    while (tick_en !== 1'b1 && r < 20) begin
      cyc();
      r++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, r;
    rst_n = 1'b0; key_start_n = 1'b1; key_lap_n = 1'b1; key_clear_n = 1'b1;
    clr_cnt();
    repeat (3) @(negedge clk);
    check("rst_hold", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    repeat (5) cyc();
    check("idle_after_rst", 32'(outs()), 32'd0);

    // Start pressed and held: one event, RUN, tick on 10th counting cycle.
    key_start_n = 1'b0;
    wait_state("start", S_RUN, n);
    check("start_lat", 32'(n), 32'd7);
    check("run_outs", 32'(outs()), 32'h05);
    run_to_tick(r);
    check("first_tick", 32'(r), 32'd10);
    clr_cnt();
    repeat (9) cyc();
    check("tick_gap", c_tick, 32'd0);
    cyc();
    check("second_tick", 32'(tick_en), 32'd1);
    check("held_one_event", 32'(state), 32'(S_RUN));
    key_start_n = 1'b1;
    repeat (10) cyc();

    // Lap glitch shorter than debounce window.
    clr_cnt();
    key_lap_n = 1'b0;
    repeat (3) cyc();
    key_lap_n = 1'b1;
    repeat (15) cyc();
    check("lap_glitch_load", c_lap_load, 32'd0);
    check("lap_glitch_state", 32'(state), 32'(S_RUN));

    // Pause pressed on a tick cycle -> held prescaler value 6.
    wait_tick("sync_tick");
    key_start_n = 1'b0;
    wait_state("pause", S_PAUSE, n);
    check("pause_lat", 32'(n), 32'd7);
    key_start_n = 1'b1;
    clr_cnt();
    repeat (50) cyc();
    check("pause_no_tick", c_tick, 32'd0);
    check("pause_hold", 32'(state), 32'(S_PAUSE));
    key_start_n = 1'b0;
    wait_state("resume", S_RUN, n);
    run_to_tick(r);
    check("resume_tick", 32'(r), 32'd4);

    // Lap from RUN on a tick cycle; cadence continues 3 cycles after entry.
    key_start_n = 1'b1;
    key_lap_n   = 1'b0;
    wait_state("lap", S_LAP, n);
    check("lap_lat", 32'(n), 32'd7);
    check("lap_outs", 32'(outs()), 32'h2F);
    clr_cnt();
    cyc();
    check("lap_load_pulse", 32'(lap_load), 32'd0);
    cyc();
    cyc();
    check("lap_tick", 32'(tick_en), 32'd1);
    check("lap_tick_count", c_tick, 32'd1);

    // Clear in LAP -> back to RUN without cnt_clr, prescaler untouched.
    key_lap_n   = 1'b1;
    key_clear_n = 1'b0;
    clr_cnt();
    wait_state("lap_clear", S_RUN, n);
    check("lap_clear_outs", 32'(outs()), 32'h05);
    check("lap_clear_no_cnt_clr", c_cnt_clr, 32'd0);
    clr_cnt();
    repeat (3) cyc();
    check("lap_clear_tick", 32'(tick_en), 32'd1);
    check("lap_clear_tick_count", c_tick, 32'd1);

    // Pause, then clear -> IDLE with both clear pulses for one cycle.
    key_clear_n = 1'b1;
    key_start_n = 1'b0;
    wait_state("pause2", S_PAUSE, n);
    key_start_n = 1'b1;
    repeat (10) cyc();
    key_clear_n = 1'b0;
    wait_state("clear", S_IDLE, n);
    check("clear_outs", 32'(outs()), 32'h50);
    cyc();
    check("clear_pulse", 32'(outs()), 32'd0);
    key_clear_n = 1'b1;
    repeat (8) cyc();

    // Restart from IDLE: prescaler was zeroed, full 10-cycle first tick.
    key_start_n = 1'b0;
    wait_state("restart", S_RUN, n);
    run_to_tick(r);
    check("restart_tick", 32'(r), 32'd10);
    key_start_n = 1'b1;
    repeat (8) cyc();

    // Start and clear together from PAUSE -> RUN only.
    key_start_n = 1'b0;
    wait_state("pause3", S_PAUSE, n);
    key_start_n = 1'b1;
    repeat (10) cyc();
    key_start_n = 1'b0;
    key_clear_n = 1'b0;
    clr_cnt();
    wait_state("dual", S_RUN, n);
    check("dual_lat", 32'(n), 32'd7);
    repeat (3) cyc();
    check("dual_state", 32'(state), 32'(S_RUN));
    check("dual_no_clr", c_cnt_clr + c_lap_clr, 32'd0);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (8) cyc();

    // Asynchronous reset mid-RUN, between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(outs()), 32'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst", 32'(outs()), 32'd0);

    // Start held through reset release must not fire.
    rst_n = 1'b0;
    key_start_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    clr_cnt();
    repeat (30) cyc();
    check("held_through_rst", 32'(state), 32'(S_IDLE));
    key_start_n = 1'b1;
    key_lap_n   = 1'b0;
    repeat (12) cyc();
    check("idle_lap_ignored", 32'(state), 32'(S_IDLE));
    check("idle_lap_no_load", c_lap_load, 32'd0);
    key_lap_n = 1'b1;
    repeat (8) cyc();
    key_start_n = 1'b0;
    wait_state("rearm", S_RUN, n);
    check("rearm_lat", 32'(n), 32'd7);
    key_start_n = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 5000000, clk cycles per tenth-second tick, range 2..2^26.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 500000, consecutive stable cycles to accept a key change, range 1..2^20.
REQ-003 SHALL have port clk, input, 1, sole clock, all flops on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_start_n, input, 1, raw start/stop key, low = pressed, asynchronous.
REQ-006 SHALL have port key_lap_n, input, 1, raw lap key, low = pressed, asynchronous.
REQ-007 SHALL have port key_clear_n, input, 1, raw clear/release key, low = pressed, asynchronous.
REQ-008 SHALL have port tick_en, output, 1, one-cycle pulse per tenth-second while counting.
REQ-009 SHALL have port cnt_clr, output, 1, one-cycle pulse zeroing the time counters.
REQ-010 SHALL have port lap_load, output, 1, one-cycle pulse capturing the live time into the lap register.
REQ-011 SHALL have port lap_clr, output, 1, one-cycle pulse zeroing the lap register.
REQ-012 SHALL have port lap_frozen, output, 1, high = display shows lap value.
REQ-013 SHALL have port running, output, 1, high in RUN or LAP.
REQ-014 SHALL have port state, output, 2, IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-015 Each key SHALL pass a 2-flop synchronizer, then a debouncer: debounced level takes the synced value only after it differs from the current debounced level for DEBOUNCE_CYC consecutive cycles; any match restarts the count.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; releases generate no event; holding a key generates exactly one event.
REQ-017 At most one event SHALL be acted on per cycle, priority start > lap > clear; lower-priority simultaneous events are discarded.
REQ-018 Event in cycle N SHALL update state and assert pulse outputs in cycle N+1 (all outputs registered).
REQ-019 IDLE: start -> RUN; clear -> cnt_clr and lap_clr pulses, stay IDLE; lap ignored.
REQ-020 RUN: start -> PAUSE; lap -> lap_load pulse, LAP; clear ignored.
REQ-021 LAP: start -> PAUSE; lap -> lap_load pulse, stay LAP (new split); clear -> RUN, no cnt_clr.
REQ-022 PAUSE: start -> RUN; lap -> lap_clr pulse, stay PAUSE; clear -> cnt_clr and lap_clr pulses, IDLE.
REQ-023 lap_frozen SHALL be 1 exactly when state is LAP.
REQ-024 Prescaler (26 bits) SHALL increment each cycle in RUN/LAP, hold its value in PAUSE, and be 0 in IDLE.
REQ-025 tick_en SHALL be 1 in the cycle the prescaler equals CLK_PER_TICK-1 in RUN/LAP; the prescaler wraps to 0 on that cycle.
REQ-026 Pausing and resuming SHALL preserve the prescaler value, so no partial tick is lost or duplicated; tick_en SHALL never assert in IDLE or PAUSE.
REQ-027 Transitions between RUN and LAP SHALL NOT disturb the prescaler.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, prescaler 0, debounce counters 0, synchronizer and debounced levels 1, and all outputs 0, independent of clk.
REQ-029 Key inputs held low through reset release SHALL NOT generate an event until released and pressed again.
REQ-030 Reset mid-operation SHALL abandon any pending pulse; the first cycle after release SHALL show IDLE with all outputs 0.

Verification (CLK_PER_TICK=10, DEBOUNCE_CYC=4)
REQ-031 Reset, then key_start_n low and held -> exactly one event, state=01, running=1, first tick_en 10 cycles after RUN entry, then every 10 cycles.
REQ-032 key_lap_n low for 3 cycles, then high, while in RUN -> no event, no lap_load, state stays 01.
REQ-033 In RUN, pause with prescaler=6, wait 50 cycles, resume -> no tick_en during PAUSE; next tick_en when prescaler reaches 9 (4th counting cycle after resume).
REQ-034 In RUN, press lap -> lap_load for 1 cycle, state=11, lap_frozen=1, tick_en cadence unchanged; press clear -> state=01, lap_frozen=0, cnt_clr stays 0.
REQ-035 In PAUSE, press clear -> cnt_clr=1 and lap_clr=1 for one cycle, state=00, prescaler 0; start and clear debounced in the same cycle from PAUSE -> RUN only, no cnt_clr.
REQ-036 rst_n low asynchronously mid-RUN -> all outputs 0 and state=00 before the next clk edge.
